// File: rtl/instruction_fetch.sv
// Fetch unit for the crush RV32I core: owns the fetch PC, issues single
// outstanding word reads, and hands instructions downstream via valid/ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  valid,
  input  logic                  ready,
  output logic                  misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {START, REQUEST, HOLD, DRAIN, FAULT} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_WIDTH-1:0] target, target_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n, pc_n;
  logic [ADDR_WIDTH-1:0] drain_tgt;
  logic [31:0]           instruction_n;
  logic                  mem_req_n, valid_n, misaligned_n;
  logic                  redirect_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= START;
      fetch_pc    <= RESET_PC;
      target      <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      valid       <= 1'b0;
      instruction <= NOP;
      pc          <= RESET_PC;
      misaligned  <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      target      <= target_n;
      mem_req     <= mem_req_n;
      mem_addr    <= mem_addr_n;
      valid       <= valid_n;
      instruction <= instruction_n;
      pc          <= pc_n;
      misaligned  <= misaligned_n;
    end
  end

  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
  // A redirect arriving in the very cycle the drained ack lands supersedes the latched target.
  assign drain_tgt    = redirect ? redirect_pc : target;

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    target_n      = target;
    mem_req_n     = mem_req;
    mem_addr_n    = mem_addr;
    valid_n       = valid;
    instruction_n = instruction;
    pc_n          = pc;
    misaligned_n  = misaligned;

    case (state)
      START, HOLD: begin
        if (redirect) begin
          valid_n = 1'b0;
          if (redirect_bad) begin
            state_n      = FAULT;
            misaligned_n = 1'b1;
            mem_req_n    = 1'b0;
          end else begin
            mem_req_n  = 1'b1;
            mem_addr_n = redirect_pc;
            state_n    = REQUEST;
          end
        end else if (state == START || ready) begin
          valid_n    = 1'b0;
          mem_req_n  = 1'b1;
          mem_addr_n = fetch_pc;
          state_n    = REQUEST;
        end
      end

      REQUEST: begin
        if (redirect) begin
          if (mem_ack) begin
            if (redirect_bad) begin
              state_n      = FAULT;
              misaligned_n = 1'b1;
              valid_n      = 1'b0;
              mem_req_n    = 1'b0;
            end else begin
              mem_addr_n = redirect_pc;
            end
          end else begin
            target_n = redirect_pc;
            state_n  = DRAIN;
          end
        end else if (mem_ack) begin
          instruction_n = mem_rdata;
          pc_n          = mem_addr;
          valid_n       = 1'b1;
          fetch_pc_n    = mem_addr + ADDR_WIDTH'(4);
          mem_req_n     = 1'b0;
          state_n       = HOLD;
        end
      end

      DRAIN: begin
        if (redirect) target_n = redirect_pc;
        if (mem_ack) begin
          if (drain_tgt[1:0] != 2'b00) begin
            state_n      = FAULT;
            misaligned_n = 1'b1;
            valid_n      = 1'b0;
            mem_req_n    = 1'b0;
          end else begin
            mem_addr_n = drain_tgt;
            state_n    = REQUEST;
          end
        end
      end

      FAULT: begin
        valid_n   = 1'b0;
        mem_req_n = 1'b0;
      end

      default: state_n = START;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed walk through the fetch scenarios followed by a randomized run
// checked against an accepted-PC-stream model and memory protocol rules.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;
  logic        ready;
  logic        misaligned;

  int n_vec  = 0;
  int n_fail = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .pc(pc), .valid(valid), .ready(ready),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    int          accepts;

    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; ready = 1'b0;
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valid", valid, 0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    check("rst_misaligned", misaligned, 0);
    reset = 1'b0;

    // Basic in-order fetch
    tick();
    check("t1_req0", mem_req, 1);
    check("t1_addr0", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0010_0093; ready = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t1_valid0", valid, 1);
    check("t1_pc0", pc, 32'h0);
    check("t1_instr0", instruction, 32'h0010_0093);
    check("t1_req_in_hold", mem_req, 0);
    tick();
    check("t1_valid_one_cycle", valid, 0);
    check("t1_addr4", mem_addr, 32'h4);
    check("t1_req4", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0020_0113; ready = 1'b0;
    tick();
    mem_ack = 1'b0;
    check("t1_pc4", pc, 32'h4);
    check("t1_instr4", instruction, 32'h0020_0113);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_valid_hold", valid, 1);
      check("t2_pc_hold", pc, 32'h4);
      check("t2_instr_hold", instruction, 32'h0020_0113);
      check("t2_req_hold", mem_req, 0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t2_next_addr", mem_addr, 32'h8);
    check("t2_next_req", mem_req, 1);
    check("t2_valid_drop", valid, 0);
    mem_ack = 1'b1; mem_rdata = memf(32'h8);
    tick();
    mem_ack = 1'b0;
    check("t2_pc8", pc, 32'h8);

    // Redirect in HOLD wins over ready
    redirect = 1'b1; redirect_pc = 32'h0000_0100; ready = 1'b1;
    tick();
    redirect = 1'b0; ready = 1'b0;
    check("t3_valid", valid, 0);
    check("t3_addr", mem_addr, 32'h100);
    check("t3_req", mem_req, 1);

    // Redirect while a request is waiting: old request must complete first
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t4_addr_kept", mem_addr, 32'h100);
      check("t4_req_kept", mem_req, 1);
      if (i < 2) tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("t4_discard_valid", valid, 0);
    check("t4_new_addr", mem_addr, 32'h200);
    check("t4_new_req", mem_req, 1);
    mem_rdata = memf(32'h200);
    tick();
    mem_ack = 1'b0;
    check("t4_pc", pc, 32'h200);
    check("t4_instr", instruction, memf(32'h200));
    check("t4_valid", valid, 1);

    // Misaligned redirect is terminal until reset
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    check("t5_misaligned", misaligned, 1);
    check("t5_req", mem_req, 0);
    check("t5_valid", valid, 0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0300; ready = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    check("t5_ignored_req", mem_req, 0);
    check("t5_still_fault", misaligned, 1);
    check("t5_ignored_valid", valid, 0);
    ready = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_reset_clears", misaligned, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_restart_req", mem_req, 1);
    check("t5_restart_addr", mem_addr, 32'h0);

    // Address wrap and asynchronous reset
    mem_ack = 1'b1; mem_rdata = memf(32'h0);
    tick();
    mem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("t6_addr_top", mem_addr, 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = memf(32'hFFFF_FFFC); ready = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_pc_top", pc, 32'hFFFF_FFFC);
    check("t6_valid_top", valid, 1);
    tick();
    ready = 1'b0;
    check("t6_wrap_addr", mem_addr, 32'h0);
    check("t6_wrap_req", mem_req, 1);
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_req", mem_req, 0);
    check("t6_async_valid", valid, 0);
    check("t6_async_addr", mem_addr, 32'h0);
    tick();
    reset = 1'b0;

    // Randomized run: accepted instructions must form the expected PC stream
    exp_pc = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0; accepts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_req && !prev_ack) begin
        check("rnd_req_held", mem_req, 1);
        check("rnd_addr_held", mem_addr, prev_addr);
      end
      if (mem_req) check("rnd_addr_align", {30'd0, mem_addr[1:0]}, 32'h0);
      ready       = 1'($urandom % 2);
      mem_ack     = mem_req && ($urandom % 3 == 0);
      mem_rdata   = mem_ack ? memf(mem_addr) : $urandom;
      redirect    = ($urandom % 16 == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (valid && ready) begin
        check("rnd_pc", pc, exp_pc);
        check("rnd_instr", instruction, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      tick();
    end
    redirect = 1'b0; mem_ack = 1'b0; ready = 1'b0;
    check("rnd_progress", {31'd0, accepts > 100}, 32'h1);
    check("rnd_no_fault", misaligned, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
